// File: rtl/serial_tx_fifo_if.sv
// Signal bundle between the receive path, the byte FIFO and the serial transmitter.
// The FIFO takes the slave modport; the side that feeds rx bytes and reports tx status takes the master modport.
interface serial_tx_fifo_if #(
  parameter int ADDR_WIDTH = 4
);
  logic                  i_Rx_DV;
  logic [7:0]            i_Rx_Byte;
  logic                  i_Tx_Active;
  logic                  i_Tx_Done;
  logic                  o_Tx_DV;
  logic [7:0]            o_Tx_Byte;
  logic [ADDR_WIDTH:0]   o_Count;
  logic                  o_Empty;
  logic                  o_Full;
  logic                  o_Overflow;
  logic [1:0]            o_State;

  // Handshake: i_Rx_DV is a 1-cycle strobe with no back-pressure, so a byte offered
  // while the FIFO is full (and not popping on that edge) is lost and flagged in o_Overflow.
  // o_Tx_DV is a 1-cycle launch strobe raised only while i_Tx_Active is low; the
  // next launch waits for i_Tx_Done plus one dead cycle.
  modport master (
    output i_Rx_DV, i_Rx_Byte, i_Tx_Active, i_Tx_Done,
    input  o_Tx_DV, o_Tx_Byte, o_Count, o_Empty, o_Full, o_Overflow, o_State
  );

  modport slave (
    input  i_Rx_DV, i_Rx_Byte, i_Tx_Active, i_Tx_Done,
    output o_Tx_DV, o_Tx_Byte, o_Count, o_Empty, o_Full, o_Overflow, o_State
  );
endinterface

// File: rtl/serial_tx_fifo.sv
// Byte FIFO between serial_rx and serial_tx: absorbs rx bursts and launches one byte
// at a time into the transmitter whenever it is idle.
module serial_tx_fifo #(
  parameter int ADDR_WIDTH = 4
) (
  input  logic             i_Clock,
  input  logic             i_Reset,
  serial_tx_fifo_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   DEPTH_C   = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  state_e                state_q;
  logic [7:0]            mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  overflow_q;
  logic                  tx_dv_q;
  logic [7:0]            tx_byte_q;

  logic full;
  logic empty;
  logic launch;
  logic push_ok;
  logic push_drop;

  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_C);

  // A launch pops, so a push on a full FIFO is still accepted on the launch edge.
  assign launch    = (state_q == ST_IDLE) && !empty && !bus.i_Tx_Active;
  assign push_ok   = bus.i_Rx_DV && (!full || launch);
  assign push_drop = bus.i_Rx_DV && !push_ok;

  always_comb begin
    count_d = count_q;
    case ({push_ok, launch})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Storage carries no reset; pointers and count alone define what is valid.
  always_ff @(posedge i_Clock) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= bus.i_Rx_Byte;
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (push_drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q   <= ST_IDLE;
      rd_ptr_q  <= '0;
      tx_dv_q   <= 1'b0;
      tx_byte_q <= 8'h00;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (launch) begin
            tx_byte_q <= mem_q[rd_ptr_q];
            rd_ptr_q  <= rd_ptr_q + PTR_ONE;
            tx_dv_q   <= 1'b1;
            state_q   <= ST_BUSY;
          end else begin
            tx_dv_q   <= 1'b0;
          end
        end
        ST_BUSY: begin
          tx_dv_q <= 1'b0;
          if (bus.i_Tx_Done) begin
            state_q <= ST_GAP;
          end
        end
        // One dead cycle lets serial_tx settle back to idle before the next launch.
        ST_GAP: begin
          tx_dv_q <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          tx_dv_q <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.o_Tx_DV     = tx_dv_q;
  assign bus.o_Tx_Byte   = tx_byte_q;
  assign bus.o_Count     = count_q;
  assign bus.o_Empty     = empty;
  assign bus.o_Full      = full;
  assign bus.o_Overflow  = overflow_q;
  assign bus.o_State     = state_q;
endmodule

// File: tb/tb_serial_tx_fifo.sv
// Directed bench for serial_tx_fifo: drives rx strobes, models serial_tx, and checks
// every launched byte against an expected queue in a separate monitor.
module tb_serial_tx_fifo;
  localparam int AW     = 4;
  localparam int TX_CYC = 20;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_tx_fifo_if #(.ADDR_WIDTH(AW)) bus();

  serial_tx_fifo #(.ADDR_WIDTH(AW)) dut (
    .i_Clock (clk),
    .i_Reset (rst),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [7:0] exp_q[$];

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // serial_tx model: busy for TX_CYC edges after sampling o_Tx_DV, then a 1-cycle done
  logic tx_busy = 1'b0;
  logic tx_done = 1'b0;
  logic hold    = 1'b0;
  int   tx_cnt  = 0;

  assign bus.i_Tx_Active = tx_busy | hold;
  assign bus.i_Tx_Done   = tx_done;

  always @(posedge clk) begin
    if (tx_cnt == 0) begin
      tx_done <= 1'b0;
      if (bus.o_Tx_DV) begin
        tx_busy <= 1'b1;
        tx_cnt  <= TX_CYC;
      end
    end else begin
      tx_cnt <= tx_cnt - 1;
      if (tx_cnt == 1) begin
        tx_busy <= 1'b0;
        tx_done <= 1'b1;
      end
    end
  end

  // monitor / scoreboard
  logic prev_dv   = 1'b0;
  int   last_done = -100;
  bit   armed     = 1'b0;
  bit   done_seen = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (tx_done) begin
        last_done = cyc + 1;
        done_seen = 1'b1;
      end
      if (bus.o_Tx_DV) begin
        check("dv_single_cycle", 32'(prev_dv), 32'd0);
        check("dv_vs_active", 32'(bus.i_Tx_Active), 32'd0);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_launch: got byte %0h want none", bus.o_Tx_Byte);
        end else begin
          check("tx_byte", 32'(bus.o_Tx_Byte), 32'(exp_q.pop_front()));
        end
        if (armed) begin
          check("launch_after_done", 32'(done_seen), 32'd1);
          check("launch_spacing", 32'((cyc - last_done) >= 2), 32'd1);
        end
        armed     = 1'b1;
        done_seen = 1'b0;
      end
    end
    prev_dv = bus.o_Tx_DV;
  end

  // driver tasks
  task automatic push(input logic [7:0] b, input bit acc);
    if (acc) exp_q.push_back(b);
    bus.i_Rx_DV   = 1'b1;
    bus.i_Rx_Byte = b;
    @(negedge clk);
    bus.i_Rx_DV   = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    armed = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (!(exp_q.size() == 0 && bus.o_Empty && bus.o_State == 2'd0 && !tx_busy && !tx_done)
           && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_in_time", 32'(n < budget), 32'd1);
    check("drain_exp_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_Rx_DV   = 1'b0;
    bus.i_Rx_Byte = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_count",    32'(bus.o_Count),    32'd0);
    check("rst_empty",    32'(bus.o_Empty),    32'd1);
    check("rst_full",     32'(bus.o_Full),     32'd0);
    check("rst_overflow", 32'(bus.o_Overflow), 32'd0);
    check("rst_tx_dv",    32'(bus.o_Tx_DV),    32'd0);
    check("rst_tx_byte",  32'(bus.o_Tx_Byte),  32'h00);
    rst = 1'b0;
    @(negedge clk);

    // single byte: launch one edge after the push, exactly one cycle wide
    push(8'h41, 1'b1);
    check("t2_count_after_push", 32'(bus.o_Count), 32'd1);
    check("t2_dv_not_yet",       32'(bus.o_Tx_DV), 32'd0);
    @(negedge clk);
    check("t2_dv_high",          32'(bus.o_Tx_DV),   32'd1);
    check("t2_byte",             32'(bus.o_Tx_Byte), 32'h41);
    check("t2_count_after_pop",  32'(bus.o_Count),   32'd0);
    @(negedge clk);
    check("t2_dv_low",           32'(bus.o_Tx_DV),   32'd0);
    wait_drain(200);

    // fill while tx is held busy, 17th byte dropped
    hold = 1'b1;
    for (int i = 0; i < 16; i++) push(8'(i), 1'b1);
    check("t3_full",  32'(bus.o_Full),  32'd1);
    check("t3_count", 32'(bus.o_Count), 32'd16);
    check("t3_no_ovf_yet", 32'(bus.o_Overflow), 32'd0);
    push(8'hFF, 1'b0);
    check("t3_overflow",     32'(bus.o_Overflow), 32'd1);
    check("t3_count_kept",   32'(bus.o_Count),    32'd16);
    hold = 1'b0;
    wait_drain(2000);
    check("t3_overflow_sticky", 32'(bus.o_Overflow), 32'd1);

    // full FIFO, push on the launch edge
    do_reset();
    check("t4_ovf_cleared", 32'(bus.o_Overflow), 32'd0);
    hold = 1'b1;
    for (int i = 0; i < 16; i++) push(8'(8'h20 + i), 1'b1);
    check("t4_full", 32'(bus.o_Full), 32'd1);
    hold = 1'b0;
    push(8'h55, 1'b1);
    check("t4_count",    32'(bus.o_Count),    32'd16);
    check("t4_overflow", 32'(bus.o_Overflow), 32'd0);
    check("t4_launch",   32'(bus.o_Tx_DV),    32'd1);
    wait_drain(2000);

    // pointer wrap: bursts of 10 with drain in between
    for (int b = 0; b < 5; b++) begin
      for (int i = 0; i < 10; i++) begin
        push(8'(8'h80 + b * 10 + i), 1'b1);
        check("t6_count_bound", 32'(bus.o_Count <= 16), 32'd1);
      end
      wait_drain(1000);
    end
    check("t6_count_zero", 32'(bus.o_Count), 32'd0);
    check("t6_no_overflow", 32'(bus.o_Overflow), 32'd0);

    // steady stream slightly slower than the tx byte time
    for (int i = 0; i < 40; i++) begin
      push(8'(8'hA0 + i * 3), 1'b1);
      repeat (23) @(negedge clk);
    end
    wait_drain(1000);
    check("t5_no_overflow", 32'(bus.o_Overflow), 32'd0);

    // reset mid-burst: 5 stored, FSM busy
    for (int i = 0; i < 6; i++) push(8'(8'h61 + i), 1'b1);
    check("t1_state_busy", 32'(bus.o_State), 32'd1);
    check("t1_count5",     32'(bus.o_Count), 32'd5);
    rst = 1'b1;
    #1;
    check("t1_rst_count", 32'(bus.o_Count), 32'd0);
    check("t1_rst_empty", 32'(bus.o_Empty), 32'd1);
    check("t1_rst_dv",    32'(bus.o_Tx_DV), 32'd0);
    check("t1_rst_state", 32'(bus.o_State), 32'd0);
    exp_q.delete();
    armed = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) push(8'(8'h71 + i), 1'b1);
    wait_drain(1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
